// File: rtl/flag_window_monitor_pkg.sv
// Shared types and constants for the flag window monitor.
package flag_window_monitor_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int CNT_W       = 8;
  localparam int WIN_LEN_DEF = 64;
  localparam int THRESH_DEF  = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/flag_win_timer.sv
// Window index counter; flags the last cycle (index WIN_LEN-1) of a running window.
module flag_win_timer #(
  parameter int WIN_LEN = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic win_end
);
  localparam int IDX_W = $clog2(WIN_LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIN_LEN - 1);

  logic [IDX_W-1:0] idx;

  assign win_end = run && (idx == LAST);

  // The start cycle is index 0, so the following cycle is already index 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         idx <= '0;
    else if (start)   idx <= IDX_W'(1);
    else if (run)     idx <= win_end ? '0 : idx + IDX_W'(1);
    else              idx <= '0;
  end
endmodule

// File: rtl/flag_window_monitor.sv
// Counts flag events per fixed-length window and raises irq on reports at or above THRESH.
module flag_window_monitor
  import flag_window_monitor_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int THRESH  = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag,
  input  logic             ack,
  output logic [CNT_W-1:0] rpt_cnt,
  output logic             irq,
  output logic             overrun,
  output logic             busy
);
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, rpt_nxt, result;
  logic             irq_nxt, ovr_nxt;
  logic             start, run, win_end;

  assign start = (state == IDLE) && flag;
  assign run   = (state == RUN);
  assign busy  = (state == RUN);

  flag_win_timer #(.WIN_LEN(WIN_LEN)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .run     (run),
    .win_end (win_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rpt_cnt <= '0;
      irq     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rpt_cnt <= rpt_nxt;
      irq     <= irq_nxt;
      overrun <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rpt_nxt   = rpt_cnt;
    irq_nxt   = irq;
    ovr_nxt   = overrun;
    result    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(flag);
    if (ack && irq) begin
      irq_nxt = 1'b0;
      ovr_nxt = 1'b0;
    end
    case (state)
      IDLE: begin
        if (flag) begin
          state_nxt = RUN;
          cnt_nxt   = CNT_W'(1);
        end
      end
      RUN: begin
        if (win_end) begin
          cnt_nxt = '0;
          if (result == '0) begin
            state_nxt = IDLE;
          end else if (!irq || ack) begin
            // Acceptance decision uses the irq seen in this cycle, before any ack clear.
            rpt_nxt = result;
            irq_nxt = (result >= THRESH_V);
          end else begin
            ovr_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = result;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_flag_window_monitor.sv
// Randomized and directed checks of flag_window_monitor against a window-level reference model.
module tb_flag_window_monitor;
  localparam int WL  = 8;
  localparam int TH  = 4;
  localparam int WL2 = 300;

  logic       clk = 1'b0, rst = 1'b0;
  logic       flag = 1'b0, ack = 1'b0, flag2 = 1'b0, ack2 = 1'b0;
  logic [7:0] rpt_cnt, rpt2;
  logic       irq, overrun, busy, irq2, ovr2, busy2;

  int checks = 0, failures = 0;

  // reference model: window activity, position, events so far, visible outputs
  bit m_act, m_irq, m_ovr;
  int m_pos, m_ev, m_rpt;

  always #5 clk = ~clk;

  flag_window_monitor #(.WIN_LEN(WL), .THRESH(TH)) dut (
    .clk(clk), .rst(rst), .flag(flag), .ack(ack),
    .rpt_cnt(rpt_cnt), .irq(irq), .overrun(overrun), .busy(busy)
  );

  flag_window_monitor #(.WIN_LEN(WL2), .THRESH(TH)) dut_sat (
    .clk(clk), .rst(rst), .flag(flag2), .ack(ack2),
    .rpt_cnt(rpt2), .irq(irq2), .overrun(ovr2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_irq = 0; m_ovr = 0; m_pos = 0; m_ev = 0; m_rpt = 0;
  endtask

  task automatic model_edge(input bit f, input bit a);
    bit old_irq;
    int res;
    old_irq = m_irq;
    if (a && old_irq) begin m_irq = 0; m_ovr = 0; end
    if (!m_act) begin
      if (f) begin m_act = 1; m_pos = 1; m_ev = 1; end
    end else begin
      res = (m_ev + int'(f) > 255) ? 255 : m_ev + int'(f);
      if (m_pos == WL - 1) begin
        m_pos = 0; m_ev = 0;
        if (res == 0) m_act = 0;
        else if (!old_irq || a) begin m_rpt = res; m_irq = (res >= TH); end
        else m_ovr = 1;
      end else begin
        m_pos++; m_ev = res;
      end
    end
  endtask

  task automatic check_all();
    chk("rpt_cnt", rpt_cnt, m_rpt);
    chk("irq", irq, m_irq);
    chk("overrun", overrun, m_ovr);
    chk("busy", busy, m_act);
  endtask

  task automatic step(input bit f, input bit a);
    flag = f; ack = a;
    @(posedge clk);
    model_edge(f, a);
    #1;
    check_all();
    flag = 0; ack = 0;
  endtask

  task automatic win(input bit [7:0] mask, input bit ack_last);
    for (int i = 0; i < WL; i++) step(mask[i], ack_last && (i == WL - 1));
  endtask

  // at index 0 of a new window: ack any pending irq and let an empty window close
  task automatic drain();
    step(0, 1);
    repeat (WL - 1) step(0, 0);
  endtask

  task automatic async_reset();
    #2 rst = 0;
    #1;
    model_reset();
    chk("rst_rpt", rpt_cnt, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    model_reset();
    #12;
    check_all();
    @(negedge clk) rst = 1;

    // threshold hit, then ack
    win(8'b1001_0101, 0);
    chk("thr_rpt", rpt_cnt, 4);
    chk("thr_irq", irq, 1);
    step(0, 1);
    chk("thr_ack_irq", irq, 0);
    chk("thr_ack_rpt", rpt_cnt, 4);
    repeat (WL - 1) step(0, 0);
    chk("thr_idle", busy, 0);

    // below threshold, then empty window returns to idle
    win(8'b0110_0001, 0);
    chk("low_rpt", rpt_cnt, 3);
    chk("low_irq", irq, 0);
    chk("low_busy", busy, 1);
    win(8'b0000_0000, 0);
    chk("low_idle", busy, 0);
    chk("low_hold", rpt_cnt, 3);

    // overrun, then ack in the window-end cycle
    win(8'b0000_1111, 0);
    chk("ovr_a_irq", irq, 1);
    win(8'b0001_1111, 0);
    chk("ovr_b_ovr", overrun, 1);
    chk("ovr_b_rpt", rpt_cnt, 4);
    win(8'b0011_1111, 1);
    chk("ovr_c_rpt", rpt_cnt, 6);
    chk("ovr_c_irq", irq, 1);
    chk("ovr_c_ovr", overrun, 0);
    drain();

    // back-to-back windows
    for (int i = 0; i < 2 * WL; i++) begin
      step(1, i == WL);
      if (i == WL - 1) begin
        chk("b2b_1_rpt", rpt_cnt, 8);
        chk("b2b_1_busy", busy, 1);
      end
    end
    chk("b2b_2_rpt", rpt_cnt, 8);
    chk("b2b_2_irq", irq, 1);
    chk("b2b_2_ovr", overrun, 0);
    chk("b2b_2_busy", busy, 1);
    drain();

    // reset mid-window with 3 events counted
    step(1, 0); step(1, 0); step(1, 0);
    async_reset();
    step(1, 0);
    chk("rst_start_busy", busy, 1);
    repeat (WL - 2) step(0, 0);
    chk("rst_early_rpt", rpt_cnt, 0);
    step(0, 0);
    chk("rst_close_rpt", rpt_cnt, 1);
    repeat (WL) step(0, 0);

    // randomized traffic with varying flag density
    p = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 4))
          0: p = 0; 1: p = 10; 2: p = 50; 3: p = 90; default: p = 100;
        endcase
      end
      if ($urandom_range(0, 499) == 0) async_reset();
      step($urandom_range(0, 99) < p, $urandom_range(0, 99) < 15);
    end

    // saturation on the long-window instance
    for (int i = 0; i < WL2; i++) begin
      flag2 = 1;
      @(posedge clk);
      #1;
      if (i == WL2 - 2) chk("sat_early_rpt", rpt2, 0);
    end
    flag2 = 0;
    chk("sat_rpt", rpt2, 255);
    chk("sat_irq", irq2, 1);
    chk("sat_busy", busy2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
